// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared encodings for the data-memory responder: access sizes,
//            read/write encoding, FSM state enum, default base address and a
//            helper returning the byte count of an access size.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Illegal size 3 is reported as 4 bytes; it is flagged as an error anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational lane logic for a 32-bit word-organised store:
//            byte enables, store-data steering into byte lanes, load
//            extraction with zero extension, and the alignment-error flag.
// Ports    : size      in  2   access size (byte/half/word/illegal)
//            addr_lo   in  2   byte offset within the word
//            wdata     in  32  store data, low bytes significant
//            rword     in  32  word currently held at the addressed location
//            byte_en   out 4   lanes written by a store
//            wlane     out 32  store data moved onto its lanes
//            rdata     out 32  zero-extended load data
//            align_err out 1   illegal size or misaligned access
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wlane,
  output logic [31:0] rdata,
  output logic        align_err
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  always_comb begin
    shamt   = {addr_lo, 3'b000};
    wlane   = wdata << shamt;
    shifted = rword >> shamt;
    byte_en = 4'b0000;
    rdata   = 32'h0;
    case (size)
      SIZE_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        rdata   = {24'h0, shifted[7:0]};
      end
      SIZE_HALF: begin
        byte_en = 4'b0011 << addr_lo;
        rdata   = {16'h0, shifted[15:0]};
      end
      SIZE_WORD: begin
        byte_en = 4'b1111;
        rdata   = shifted;
      end
      default: begin
        byte_en = 4'b0000;
        rdata   = 32'h0;
      end
    endcase
    align_err = (size == 2'd3) ||
                ((size == SIZE_HALF) && addr_lo[0]) ||
                ((size == SIZE_WORD) && (addr_lo != 2'b00));
  end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle valid/ready data-memory target. Accepts one
//            load/store at a time, commits it after LATENCY cycles on
//            internal byte-addressable storage and holds the response until
//            the core consumes it.
// Ports    : clock, reset            clock, synchronous active-high reset
//            req_valid/req_ready     request handshake
//            req_addr/rw/size/wdata  request payload
//            rsp_valid/rsp_ready     response handshake
//            rsp_rdata/rsp_err       response payload
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_BYTES = 65536,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam int          WORDS     = DEPTH_BYTES / 4;
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_BYTES) - 33'd1;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, commit;

  logic [31:0] lat_addr, lat_wdata;
  logic        lat_rw;
  logic [1:0]  lat_size;

  // With LATENCY==1 the commit edge is the acceptance edge, so the request
  // must be taken straight from the inputs rather than from the latch.
  logic [31:0] eff_addr, eff_wdata;
  logic        eff_rw;
  logic [1:0]  eff_size;

  logic [AW-1:0]     off;
  logic [32:0]       end_addr;
  logic              range_err, align_err, req_err, mem_we;
  logic [3:0]        byte_en;
  logic [31:0]       wlane, lane_rdata;
  logic [3:0][7:0]   rbytes;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~reset;
        if (req_valid && !reset) begin
          accept   = 1'b1;
          cnt_next = CNT_LOAD;
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // Counter hits zero on the same edge that enters RESP.
        if (cnt <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          commit     = ~reset;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    eff_addr  = (state == IDLE) ? req_addr  : lat_addr;
    eff_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    eff_rw    = (state == IDLE) ? req_rw    : lat_rw;
    eff_size  = (state == IDLE) ? req_size  : lat_size;
    off       = AW'(eff_addr - BASE_ADDR);
    // 33-bit end address so a request near 0xFFFF_FFFF cannot wrap into range.
    end_addr  = {1'b0, eff_addr} + {30'h0, size_bytes(eff_size)} - 33'd1;
    range_err = (eff_addr < BASE_ADDR) || (end_addr > LAST_ADDR);
    req_err   = range_err | align_err;
    mem_we    = commit && !req_err && (eff_rw == RW_WRITE);
  end

  mem_lane_align u_lane (
    .size      (eff_size),
    .addr_lo   (off[1:0]),
    .wdata     (eff_wdata),
    .rword     (rbytes),
    .byte_en   (byte_en),
    .wlane     (wlane),
    .rdata     (lane_rdata),
    .align_err (align_err)
  );

  // One byte bank per lane so each lane has a single writer.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] bank [WORDS];
    always_ff @(posedge clock) begin
      if (mem_we && byte_en[b]) bank[off[AW-1:2]] <= wlane[8*b +: 8];
    end
    assign rbytes[b] = bank[off[AW-1:2]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_rw    <= RW_READ;
      lat_size  <= SIZE_BYTE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_rw    <= req_rw;
        lat_size  <= req_size;
      end
      if (commit) begin
        rsp_err   <= req_err;
        rsp_rdata <= (req_err || (eff_rw == RW_WRITE)) ? 32'h0 : lane_rdata;
      end
    end
  end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder with three instances at
//            LATENCY 2, 4 and 1 sharing clock, reset and request payload.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       req_valid = 3'b000;
  logic [2:0]       req_ready, rsp_valid, rsp_err;
  logic [31:0]      req_addr = 32'h0, req_wdata = 32'h0;
  logic             req_rw = 1'b0;
  logic [1:0]       req_size = 2'd0;
  logic             rsp_ready = 1'b0;
  logic [2:0][31:0] rsp_rdata;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  dmem_responder #(.LATENCY(2)) u_lat2 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr), .req_rw(req_rw), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.LATENCY(4)) u_lat4 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr), .req_rw(req_rw), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr), .req_rw(req_rw), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       lat_of = 2;
      1:       lat_of = 4;
      default: lat_of = 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete transaction on instance i, with latency and payload checks.
  task automatic do_req(input int i, input logic [31:0] addr, input logic rw,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input string tag);
    int   k;
    exp_t e;
    sb.push_back('{exp_rdata, exp_err});
    req_addr  = addr;
    req_rw    = rw;
    req_size  = size;
    req_wdata = wdata;
    req_valid[i] = 1'b1;
    k = 0;
    while (!req_ready[i] && k < 20) begin tick(); k++; end
    chk({tag, " req_ready"}, 32'(req_ready[i]), 32'd1);
    tick();
    req_valid[i] = 1'b0;
    k = 0;
    while (!rsp_valid[i] && k < 20) begin tick(); k++; end
    chk({tag, " latency"}, k, lat_of(i) - 1);
    e = sb.pop_front();
    chk({tag, " rdata"}, rsp_rdata[i], e.rdata);
    chk({tag, " err"}, 32'(rsp_err[i]), 32'(e.err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, " back_to_idle"}, {30'h0, rsp_valid[i], req_ready[i]}, 32'h1);
  endtask

  initial begin
    int   k, t, last_acc, n_acc, n_rsp;
    exp_t e;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'h0);
    chk("rst rsp_rdata", rsp_rdata[0], 32'h0);
    reset = 1'b0;
    #1;
    chk("post-rst req_ready", 32'(req_ready), 32'h7);

    // 1. word write then read
    do_req(0, 32'h0100_0010, RW_WRITE, SIZE_WORD, 32'hDEAD_BEEF, 32'h0, 1'b0, "t1 wr");
    do_req(0, 32'h0100_0010, RW_READ,  SIZE_WORD, 32'h0, 32'hDEAD_BEEF, 1'b0, "t1 rd");

    // 2. sub-word
    do_req(0, 32'h0100_0011, RW_WRITE, SIZE_BYTE, 32'hAAAA_AA55, 32'h0, 1'b0, "t2 wrb");
    do_req(0, 32'h0100_0010, RW_READ,  SIZE_WORD, 32'h0, 32'hDEAD_55EF, 1'b0, "t2 rdw");
    do_req(0, 32'h0100_0012, RW_READ,  SIZE_HALF, 32'h0, 32'h0000_DEAD, 1'b0, "t2 rdh");
    do_req(0, 32'h0100_0011, RW_READ,  SIZE_BYTE, 32'h0, 32'h0000_0055, 1'b0, "t2 rdb");

    // 3. errors and range boundaries
    do_req(0, 32'h0100_0011, RW_WRITE, SIZE_HALF, 32'hFFFF_FFFF, 32'h0, 1'b1, "t3 mis_h");
    do_req(0, 32'h0000_0000, RW_READ,  SIZE_WORD, 32'h0, 32'h0, 1'b1, "t3 zero");
    do_req(0, 32'h0100_FFFE, RW_READ,  SIZE_WORD, 32'h0, 32'h0, 1'b1, "t3 top-2");
    do_req(0, 32'h0101_0000, RW_READ,  SIZE_WORD, 32'h0, 32'h0, 1'b1, "t3 past_end");
    do_req(0, 32'hFFFF_FFFC, RW_READ,  SIZE_WORD, 32'h0, 32'h0, 1'b1, "t3 wrap");
    do_req(0, 32'h00FF_FFFF, RW_READ,  SIZE_BYTE, 32'h0, 32'h0, 1'b1, "t3 below");
    do_req(0, 32'h0100_0010, RW_WRITE, 2'd3, 32'h0, 32'h0, 1'b1, "t3 size3");
    do_req(0, 32'h0100_FFFC, RW_WRITE, SIZE_WORD, 32'h1122_3344, 32'h0, 1'b0, "t3 last_w");
    do_req(0, 32'h0100_FFFF, RW_WRITE, SIZE_BYTE, 32'h0000_0077, 32'h0, 1'b0, "t3 last_b");
    do_req(0, 32'h0100_FFFC, RW_READ,  SIZE_WORD, 32'h0, 32'h7722_3344, 1'b0, "t3 rd_lw");
    do_req(0, 32'h0100_FFFE, RW_READ,  SIZE_HALF, 32'h0, 32'h0000_7722, 1'b0, "t3 rd_lh");
    do_req(0, 32'h0100_0010, RW_READ,  SIZE_WORD, 32'h0, 32'hDEAD_55EF, 1'b0, "t3 intact");

    // 4. backpressure; a write held on the request port meanwhile is ignored
    req_addr = 32'h0100_0010; req_rw = RW_READ; req_size = SIZE_WORD;
    req_valid[0] = 1'b1;
    tick();
    req_rw = RW_WRITE; req_wdata = 32'h0;
    k = 0;
    while (!rsp_valid[0] && k < 20) begin tick(); k++; end
    for (int c = 0; c < 5; c++) begin
      chk("t4 rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t4 rdata", rsp_rdata[0], 32'hDEAD_55EF);
      chk("t4 err", 32'(rsp_err[0]), 32'd0);
      chk("t4 req_ready", 32'(req_ready[0]), 32'd0);
      tick();
    end
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4 idle", {30'h0, rsp_valid[0], req_ready[0]}, 32'h1);
    do_req(0, 32'h0100_0010, RW_READ, SIZE_WORD, 32'h0, 32'hDEAD_55EF, 1'b0, "t4 ignored");

    // 5. reset mid-operation, LATENCY 4
    do_req(1, 32'h0100_0020, RW_WRITE, SIZE_WORD, 32'h0BAD_F00D, 32'h0, 1'b0, "t5 pre_w");
    do_req(1, 32'h0100_0020, RW_READ,  SIZE_WORD, 32'h0, 32'h0BAD_F00D, 1'b0, "t5 pre_r");
    req_addr = 32'h0100_0020; req_rw = RW_WRITE; req_size = SIZE_WORD;
    req_wdata = 32'h1234_5678;
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    chk("t5 wait1", 32'(rsp_valid[1]), 32'd0);
    tick();
    chk("t5 wait2", 32'(rsp_valid[1]), 32'd0);
    reset = 1'b1;
    tick();
    chk("t5 rst rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("t5 rst rdata", rsp_rdata[1], 32'h0);
    chk("t5 rst err", 32'(rsp_err[1]), 32'd0);
    chk("t5 rst req_ready", 32'(req_ready[1]), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5 ready after", 32'(req_ready[1]), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5 no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    do_req(1, 32'h0100_0020, RW_READ, SIZE_WORD, 32'h0, 32'h0BAD_F00D, 1'b0, "t5 lost_w");

    // 6. LATENCY 1 back-to-back
    for (int j = 0; j < 4; j++)
      do_req(2, 32'h0100_0040 + 32'(4 * j), RW_WRITE, SIZE_WORD,
             32'hC0DE_0000 | 32'(j), 32'h0, 1'b0, "t6 pre");
    rsp_ready = 1'b1; req_rw = RW_READ; req_size = SIZE_WORD;
    req_valid[2] = 1'b1;
    t = 0; last_acc = -10; n_acc = 0; n_rsp = 0;
    while (n_rsp < 6 && t < 60) begin
      req_addr = 32'h0100_0040 + 32'(4 * (n_acc % 4));
      if (n_acc >= 6) req_valid[2] = 1'b0;
      if (rsp_valid[2]) begin
        chk("t6 sb_nonempty", 32'(sb.size() > 0), 32'd1);
        e = sb.pop_front();
        chk("t6 rdata", rsp_rdata[2], e.rdata);
        chk("t6 rsp_gap", t - last_acc, 32'd1);
        n_rsp++;
      end
      chk("t6 overlap", 32'(req_ready[2] & rsp_valid[2]), 32'd0);
      if (req_ready[2] && req_valid[2]) begin
        if (n_acc > 0) chk("t6 acc_gap", t - last_acc, 32'd2);
        sb.push_back('{32'hC0DE_0000 | 32'(n_acc % 4), 1'b0});
        last_acc = t;
        n_acc++;
      end
      tick();
      t++;
    end
    chk("t6 rsp_count", n_rsp, 32'd6);
    req_valid[2] = 1'b0;
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle, handshaked data-memory responder. It is the target side of the processor's data-memory port.
- Accepts one load/store request at a time from the core's memory stage.
- Performs a byte/half/word access on internal byte-addressable storage after a fixed latency.
- Returns a response through a valid/ready handshake. Replaces the zero-latency combinational data memory when the core moves to stalling memory accesses.

Parameters:
- BASE_ADDR, 32'h0100_0000, first byte address mapped by the storage.
- DEPTH_BYTES, 65536, storage size in bytes; must be a power of two and at least 4.
- LATENCY, 2, cycles from request acceptance to first rsp_valid; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address.
- req_rw  in  1  0=read, 1=write.
- req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=illegal.
- req_wdata  in  32  store data; low bytes are used per size.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core consumes the response.
- rsp_rdata  out  32  load data, zero-extended; 0 for writes and errors.
- rsp_err  out  1  request was illegal; no storage side effect.

Behaviour:
- Reset, while reset=1 at an edge:
  - State goes to IDLE.
  - req_ready=0 during the reset cycle; it rises to 1 in the first cycle after reset deasserts.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Storage contents are not reset.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0.
    - On req_valid&req_ready: latch addr/rw/size/wdata, load counter=LATENCY-1.
    - Go to RESP if LATENCY==1, else to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle; when the counter reaches 0, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until rsp_ready=1. On rsp_valid&rsp_ready, go to IDLE.
- Latency and throughput:
  - A request accepted at edge N gives rsp_valid=1 in the cycle after edge N+LATENCY-1. That is, rsp_valid is first visible LATENCY cycles after the acceptance cycle.
  - A new request cannot be accepted in the same cycle as the response handshake. Back-to-back throughput is one request per LATENCY+1 cycles minimum.
- Commit point:
  - The storage write and the read sampling happen on the edge that enters RESP.
  - The response registers are loaded on that same edge.
- Error check, evaluated on the latched request. An error is any of:
  - size==3.
  - Misalignment: size==1 with addr[0]=1, or size==2 with addr[1:0]!=0.
  - Out of range: addr<BASE_ADDR, or addr+bytes-1 > BASE_ADDR+DEPTH_BYTES-1. Compute with a 33-bit sum so 0xFFFF_FFFF does not wrap.
  - On error: rsp_err=1, rsp_rdata=0, storage unchanged.
- Data layout:
  - Little-endian. Offset = addr-BASE_ADDR.
  - A byte write stores wdata[7:0] at offset; a half write stores wdata[15:0] at offset..offset+1; a word write stores all 4 bytes.
  - A read returns zero-extended {bytes}; e.g. byte read = {24'b0, mem[off]}.
  - Write responses: rsp_rdata=0, rsp_err=0 unless illegal.
- Request inputs are ignored outside the IDLE state (req_ready=0).
- Reset mid-operation (WAIT or RESP): the transaction is dropped with no response.
  - A write is lost if reset arrives before the RESP entry edge.
  - A write already committed stays in storage.
- rsp_ready held high before rsp_valid is legal; the handshake completes in the first RESP cycle.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - state enum {IDLE, WAIT, RESP}.
  - default BASE_ADDR constant.
  - rw encoding (RW_READ=0, RW_WRITE=1).
- One sub-module, mem_lane_align: combinational byte-enable generation, store-data lane steering, load extraction/zero-extension, and the alignment-error flag. The top keeps the FSM, counter, range check and storage.

Test Plan:
1. Word write then read, LATENCY=2:
   - Write 0x0100_0010 / 0xDEAD_BEEF → rsp_valid 2 cycles after acceptance, rsp_err=0, rsp_rdata=0.
   - Read word at the same address → rsp_rdata=0xDEAD_BEEF.
2. Sub-word writes then reads, after test 1:
   - Byte write 0x55 to 0x0100_0011, then word read at 0x0100_0010 → 0xDEAD_55EF.
   - Half read at 0x0100_0012 → 0x0000_DEAD.
3. Errors, checked with a later word read of 0x0100_0010:
   - Half write at 0x0100_0011 → rsp_err=1, storage unchanged.
   - Word read at 0x0000_0000 → rsp_err=1.
   - Word read at BASE_ADDR+DEPTH_BYTES-2 → rsp_err=1.
   - size=3 → rsp_err=1.
4. Backpressure:
   - Hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0 throughout.
   - Assert rsp_ready → IDLE next cycle with req_ready=1.
5. Reset mid-operation:
   - Issue a word write of 0x1234_5678 to 0x0100_0020 with LATENCY=4 and pulse reset 2 cycles after acceptance → no rsp_valid, outputs 0.
   - A later read at 0x0100_0020 returns the prior contents, not 0x1234_5678.
6. LATENCY=1 back-to-back:
   - Drive req_valid continuously with rsp_ready=1 → acceptances every 2 cycles.
   - rsp_valid the cycle after each acceptance; no acceptance coincides with rsp_valid.
